qspi_line_ctrl: RTL and testbench

- Off-chip memory port for the vc CPU. Sits directly downstream of the I/D cache fill/writeback logic and upstream of the uio pins.
- Takes one cache-line request at a time: a 24-bit physical line address and read/write.
- Serialises the request as a quad-SPI transaction: command, address, dummy, data.
- Returns read words as a stream and pulls write words from the cache on demand.

---
 rtl/qspi_pkg.sv | 17 +
 rtl/qspi_nibble_shift.sv | 26 ++
 rtl/qspi_line_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_qspi_line_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI cache-line memory port.
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } state_e;

    localparam logic [7:0] CMD_QREAD    = 8'hEB;
    localparam logic [7:0] CMD_QWRITE   = 8'h38;
    localparam int         ADDR_NIBBLES = 6;

endpackage

// File: rtl/qspi_nibble_shift.sv
// 16-bit nibble shifter: assembles read words from io_in and serialises write
// words MSB nibble first; a load takes priority over a shift.
module qspi_nibble_shift
    import qspi_pkg::*;
(
    input  logic        clk_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        shift_i,
    input  logic [3:0]  nib_i,
    output logic [15:0] q_o
);

    logic [15:0] sh_q;

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            sh_q <= load_val_i;
        end else if (shift_i) begin
            sh_q <= {sh_q[11:0], nib_i};
        end
    end

    assign q_o = sh_q;

endmodule

// File: rtl/qspi_line_ctrl.sv
// Quad-SPI cache-line read/write port (CMD, ADDR, DUMMY, DATA, GAP).
// Define QSPI_WRITE_EN to build the write path; otherwise every request is a read.
module qspi_line_ctrl
    import qspi_pkg::*;
#(
    parameter int PA         = 24,
    parameter int LINE_WORDS = 4,
    parameter int DUMMY      = 4,
    parameter int CS_GAP     = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          req_write,
    input  logic [PA-1:0] req_addr,
    output logic          req_ack,
    output logic          busy,
    output logic [15:0]   rdata,
    output logic          rdata_valid,
    input  logic [15:0]   wdata,
    output logic          wdata_ready,
    output logic          spi_sck,
    output logic          spi_cs_n,
    output logic [3:0]    spi_io_out,
    output logic [3:0]    spi_io_oe,
    input  logic [3:0]    spi_io_in
);

    localparam int            OFS_W      = $clog2(LINE_WORDS * 2);
    localparam logic [PA-1:0] ALIGN_MASK = {PA{1'b1}} << OFS_W;
    localparam int            WW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int            CW         = 8;
    localparam logic [WW-1:0] LAST_WORD  = WW'(LINE_WORDS - 1);
    localparam logic [CW-1:0] LAST_ADDR  = CW'(ADDR_NIBBLES - 1);
    localparam logic [CW-1:0] LAST_DUMMY = CW'(DUMMY - 1);
    localparam logic [CW-1:0] LAST_GAP   = CW'(CS_GAP - 1);

    state_e        state_q, state_d;
    logic          half_q, half_d;
    logic [CW-1:0] nib_q, nib_d;
    logic [WW-1:0] word_q, word_d;
    logic [PA-1:0] addr_q, addr_d;
    logic          wr_q, wr_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          wrdy, sh_shift, active;
    logic [15:0]   sh_q;
    logic [7:0]    cmd_byte;
    logic [4:0]    addr_sh;
    logic [3:0]    addr_nib;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            half_q   <= 1'b0;
            nib_q    <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            nib_q    <= nib_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

`ifdef QSPI_WRITE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
        end
    end
    assign wdata_ready = wrdy;
`else
    logic unused_wr;
    assign wr_q        = 1'b0;
    assign unused_wr   = wr_d;
    assign wdata_ready = 1'b0;
`endif

    // Write words go out low byte first, so swap bytes on load.
    qspi_nibble_shift u_shift (
        .clk_i      (clk),
        .load_i     (wrdy),
        .load_val_i ({wdata[7:0], wdata[15:8]}),
        .shift_i    (sh_shift),
        .nib_i      (spi_io_in),
        .q_o        (sh_q)
    );

    assign cmd_byte = wr_q ? CMD_QWRITE : CMD_QREAD;
    assign addr_sh  = 5'(4 * (int'(LAST_ADDR) - int'(nib_q)));
    assign addr_nib = 4'(addr_q >> addr_sh);

    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        nib_d    = nib_q;
        word_d   = word_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wrdy     = 1'b0;
        sh_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_CMD;
                    addr_d  = req_addr & ALIGN_MASK;
                    wr_d    = req_write;
                    half_d  = 1'b0;
                    nib_d   = '0;
                    word_d  = '0;
                end
            end
            ST_CMD: begin
                half_d = ~half_q;
                if (half_q) begin
                    if (nib_q == CW'(1)) begin
                        nib_d   = '0;
                        state_d = ST_ADDR;
                    end else begin
                        nib_d = nib_q + CW'(1);
                    end
                end
            end
            ST_ADDR: begin
                half_d = ~half_q;
                if (half_q) begin
                    if (nib_q == LAST_ADDR) begin
                        nib_d   = '0;
                        wrdy    = wr_q;
                        state_d = (wr_q || DUMMY == 0) ? ST_DATA : ST_DUMMY;
                    end else begin
                        nib_d = nib_q + CW'(1);
                    end
                end
            end
            ST_DUMMY: begin
                half_d = ~half_q;
                if (half_q) begin
                    if (nib_q == LAST_DUMMY) begin
                        nib_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        nib_d = nib_q + CW'(1);
                    end
                end
            end
            ST_DATA: begin
                half_d = ~half_q;
                if (half_q) begin
                    sh_shift = 1'b1;
                    if (nib_q == CW'(3)) begin
                        nib_d = '0;
                        if (!wr_q) begin
                            // Nibbles arrive lo[7:4], lo[3:0], hi[7:4], hi[3:0].
                            rvalid_d = 1'b1;
                            rdata_d  = {sh_q[3:0], spi_io_in, sh_q[11:4]};
                        end
                        if (word_q == LAST_WORD) begin
                            state_d = ST_GAP;
                        end else begin
                            word_d = word_q + WW'(1);
                            wrdy   = wr_q;
                        end
                    end else begin
                        nib_d = nib_q + CW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (nib_q == LAST_GAP) begin
                    nib_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    nib_d = nib_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        active     = state_q inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
        spi_cs_n   = ~active;
        spi_sck    = active & half_q;
        spi_io_out = '0;
        spi_io_oe  = '0;
        case (state_q)
            ST_CMD: begin
                spi_io_oe  = 4'hF;
                spi_io_out = (nib_q == '0) ? cmd_byte[7:4] : cmd_byte[3:0];
            end
            ST_ADDR: begin
                spi_io_oe  = 4'hF;
                spi_io_out = addr_nib;
            end
            ST_DATA: begin
                if (wr_q) begin
                    spi_io_oe  = 4'hF;
                    spi_io_out = sh_q[15:12];
                end
            end
            default: ;
        endcase
        // The first GAP cycle is the completion cycle.
        req_ack = (state_q == ST_GAP) && (nib_q == '0);
        busy    = active | req_ack;
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;

endmodule

// File: tb/tb_qspi_line_ctrl.sv
// Self-checking bench for qspi_line_ctrl: directed and random line transfers
// checked against a nibble-level model of the quad-SPI transaction.
module tb_qspi_line_ctrl;

    localparam int LW  = 4;
    localparam int DMY = 4;
    localparam int CSG = 2;

    logic        clk = 1'b0;
    logic        reset, req, req_write, req_ack, busy, rdata_valid, wdata_ready;
    logic        spi_sck, spi_cs_n;
    logic [23:0] req_addr;
    logic [15:0] rdata, wdata;
    logic [3:0]  spi_io_out, spi_io_oe, spi_io_in;

    always #5 clk = ~clk;

    qspi_line_ctrl #(.PA(24), .LINE_WORDS(LW), .DUMMY(DMY), .CS_GAP(CSG)) dut (
        .clk(clk), .reset(reset), .req(req), .req_write(req_write), .req_addr(req_addr),
        .req_ack(req_ack), .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid),
        .wdata(wdata), .wdata_ready(wdata_ready), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_io_out(spi_io_out), .spi_io_oe(spi_io_oe), .spi_io_in(spi_io_in)
    );

    int          n_cmp = 0, n_fail = 0;
    int          cyc = 0, sck_cnt = 0, wptr = 0, ack_cnt = 0, ack_cyc = -1, bad_hold = 0, t0 = -1;
    logic [3:0]  obs_out[$];
    logic [3:0]  obs_oe[$];
    logic [15:0] rd_q[$];
    logic [7:0]  fb[2*LW];
    logic [15:0] ww[LW];
    bit          cur_wr;
    logic [23:0] cur_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flash model: data nibble d is byte d/2 of the line, high nibble first.
    function automatic logic [3:0] flash_nib(input int k);
        int d;
        d = k - (8 + DMY);
        if (d < 0 || d >= 4 * LW) return 4'($urandom);
        return (d % 2 == 0) ? fb[d / 2][7:4] : fb[d / 2][3:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (spi_cs_n) begin
            sck_cnt = 0;
        end else if (spi_sck) begin
            obs_out.push_back(spi_io_out);
            obs_oe.push_back(spi_io_oe);
            sck_cnt++;
        end else begin
            spi_io_in = flash_nib(sck_cnt);
        end
        if (rdata_valid) rd_q.push_back(rdata);
        if (wdata_ready) begin
            wdata = ww[wptr % LW];
            wptr++;
        end
        if (req_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
    endtask

    task automatic prep();
        obs_out.delete();
        obs_oe.delete();
        rd_q.delete();
        wptr = 0; ack_cnt = 0; ack_cyc = -1; bad_hold = 0;
    endtask

    task automatic randomize_line();
        for (int i = 0; i < 2 * LW; i++) fb[i] = 8'($urandom);
        for (int i = 0; i < LW; i++) ww[i] = 16'($urandom);
    endtask

    task automatic start_txn(input bit wr, input logic [23:0] a);
        int n;
        req_write = wr;
        req_addr  = a;
        req       = 1'b1;
`ifdef QSPI_WRITE_EN
        cur_wr = wr;
`else
        cur_wr = 1'b0;
`endif
        cur_addr = a & ~24'(2 * LW - 1);
        n  = 0;
        t0 = -1;
        while (t0 < 0 && n < 50) begin
            step();
            n++;
            if (busy) t0 = cyc;
        end
        check("accept_seen", 32'(t0 >= 0), 1);
        if (t0 >= 0) check("cs_low_at_accept", spi_cs_n, 0);
    endtask

    task automatic finish_txn(input bit drop, input bit hold);
        int n, ne, d, w, j;
        logic [7:0] cb, by;
        logic [3:0] eo, eoe;
        bit chk_out;
        n = 0;
        if (drop) req = 1'b0;
        while (ack_cnt == 0 && n < 300) begin
            if (spi_cs_n || !busy) bad_hold++;
            step();
            n++;
        end
        check("ack_seen", ack_cnt, 1);
        check("latency", ack_cyc - t0, 2 * (8 + (cur_wr ? 0 : DMY) + 4 * LW));
        check("busy_at_ack", busy, 1);
        check("cs_high_at_ack", spi_cs_n, 1);
        check("oe_off_at_ack", spi_io_oe, 0);
        check("cs_busy_hold", bad_hold, 0);

        cb = cur_wr ? 8'h38 : 8'hEB;
        ne = 8 + (cur_wr ? 0 : DMY) + 4 * LW;
        check("nibble_count", obs_out.size(), ne);
        for (int k = 0; k < ne && k < obs_out.size(); k++) begin
            chk_out = 1'b1;
            eoe     = 4'hF;
            if (k < 2) begin
                eo = (k == 0) ? cb[7:4] : cb[3:0];
            end else if (k < 8) begin
                eo = 4'(cur_addr >> (4 * (7 - k)));
            end else if (!cur_wr && k < 8 + DMY) begin
                eo  = 4'h0;
                eoe = 4'h0;
            end else begin
                d  = k - (cur_wr ? 8 : 8 + DMY);
                w  = d / 4;
                j  = d % 4;
                by = (j < 2) ? ww[w][7:0] : ww[w][15:8];
                eo = (j % 2 == 0) ? by[7:4] : by[3:0];
                if (!cur_wr) begin
                    eoe     = 4'h0;
                    chk_out = 1'b0;
                end
            end
            check($sformatf("oe[%0d]", k), obs_oe[k], eoe);
            if (chk_out) check($sformatf("io_out[%0d]", k), obs_out[k], eo);
        end

        check("rdata_count", rd_q.size(), cur_wr ? 0 : LW);
        for (int i = 0; i < rd_q.size() && i < LW; i++)
            check($sformatf("rdata[%0d]", i), rd_q[i], {fb[2 * i + 1], fb[2 * i]});
        check("wdata_ready_count", wptr, cur_wr ? LW : 0);

        if (!hold) begin
            req = 1'b0;
            step();
            check("busy_after_ack", busy, 0);
            check("ack_one_cycle", req_ack, 0);
            repeat (CSG + 2) step();
            check("single_ack", ack_cnt, 1);
        end
    endtask

    initial begin
        int n, g;
        reset = 1'b1; req = 1'b0; req_write = 1'b0; req_addr = '0;
        wdata = '0; spi_io_in = '0;
        repeat (3) step();
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sck", spi_sck, 0);
        check("rst_oe", spi_io_oe, 0);
        check("rst_io_out", spi_io_out, 0);
        check("rst_ack", req_ack, 0);
        check("rst_rvalid", rdata_valid, 0);
        check("rst_wready", wdata_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 0);
        reset = 1'b0;
        step();

        // Directed read of the documented line.
        for (int i = 0; i < 2 * LW; i++) fb[i] = 8'((i + 1) * 17);
        prep(); start_txn(1'b0, 24'h012345); finish_txn(1'b0, 1'b0);

        // Directed write (runs as a read when the write path is not built).
        randomize_line();
        ww[0] = 16'h1234; ww[1] = 16'h5678; ww[2] = 16'h9ABC; ww[3] = 16'hDEF0;
        prep(); start_txn(1'b1, 24'hABCDE0); finish_txn(1'b0, 1'b0);

        // Request dropped right after acceptance.
        randomize_line();
        prep(); start_txn(1'($urandom_range(0, 1)), 24'($urandom)); finish_txn(1'b1, 1'b0);

        // Back-to-back with req held across the ack.
        randomize_line();
        prep(); start_txn(1'b0, 24'h5A5A5F); finish_txn(1'b0, 1'b1);
        prep();
        g = 1; n = 0; t0 = -1;
        while (t0 < 0 && n < 50) begin
            step();
            n++;
            if (!spi_cs_n) t0 = cyc;
            else g++;
        end
        check("b2b_accept", 32'(t0 >= 0), 1);
        check("b2b_gap_ok", 32'(g >= CSG), 1);
        finish_txn(1'b0, 1'b0);

        // Reset at the third data nibble of a read aborts the transaction.
        randomize_line();
        prep(); start_txn(1'b0, 24'($urandom));
        n = 0;
        while (!(sck_cnt == 8 + DMY + 2 && !spi_sck && !spi_cs_n) && n < 200) begin
            step();
            n++;
        end
        check("abort_point_reached", 32'(n < 200), 1);
        reset = 1'b1; req = 1'b0;
        step();
        check("abort_cs_n", spi_cs_n, 1);
        check("abort_oe", spi_io_oe, 0);
        check("abort_busy", busy, 0);
        check("abort_sck", spi_sck, 0);
        check("abort_ack", req_ack, 0);
        reset = 1'b0;
        repeat (80) step();
        check("abort_no_ack", ack_cnt, 0);
        check("abort_no_rdata", rd_q.size(), 0);
        check("abort_no_wready", wptr, 0);
        randomize_line();
        prep(); start_txn(1'b0, 24'($urandom)); finish_txn(1'b0, 1'b0);

        // Random transactions.
        for (int t = 0; t < 8; t++) begin
            randomize_line();
            prep();
            start_txn(1'($urandom_range(0, 1)), 24'($urandom));
            finish_txn(1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
